// File: rtl/icache_dm_if.sv
// CPU fetch port and backing-memory port of the direct-mapped instruction cache.
// The cache is the slave; the CPU/memory environment is the master.
interface icache_dm_if;
  logic        cpu_rd;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        hold;
  logic        flush;
  logic        mem_ce_n;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output cpu_rd, cpu_addr, flush, mem_data, mem_ack,
    input  cpu_data, hold, mem_ce_n, mem_addr, hit_cnt, miss_cnt
  );

  modport slave (
    input  cpu_rd, cpu_addr, flush, mem_data, mem_ack,
    output cpu_data, hold, mem_ce_n, mem_addr, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache, 4-word lines, combinational hit path and
// word-by-word line fill from a slow backing memory.
module icache_dm #(
  parameter int unsigned LINES         = 16,
  parameter logic [31:0] START_ADDRESS = 32'h00400000
) (
  input  logic      clk,
  input  logic      reset_n,
  icache_dm_if.slave bus
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 28 - IW;

  typedef enum logic {IDLE, FILL} state_t;

  state_t state, state_next;

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [1:0]    req_off;
  logic          addr_unused;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*4];

  logic [27:0]   line_base;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic [1:0]    word_cnt;
  logic          pending;
  logic [31:0]   mem_addr_q;
  logic [31:0]   hit_cnt_q;
  logic [31:0]   miss_cnt_q;

  logic        do_hit;
  logic        do_miss;
  logic        fill_wr;
  logic        fill_done;
  logic        hold_c;
  logic [31:0] cpu_data_c;

  assign req_idx     = bus.cpu_addr[IW+3:4];
  assign req_tag     = bus.cpu_addr[31:IW+4];
  assign req_off     = bus.cpu_addr[3:2];
  assign addr_unused = ^bus.cpu_addr[1:0];

  assign fill_idx = line_base[IW-1:0];
  assign fill_tag = line_base[27:IW];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_hit     = 1'b0;
    do_miss    = 1'b0;
    fill_wr    = 1'b0;
    fill_done  = 1'b0;
    hold_c     = 1'b0;
    cpu_data_c = '0;
    if (!reset_n) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_rd) begin
            if (valid[req_idx] && (tag_mem[req_idx] == req_tag)) begin
              do_hit     = 1'b1;
              cpu_data_c = data_mem[{req_idx, req_off}];
            end else begin
              do_miss    = 1'b1;
              hold_c     = 1'b1;
              state_next = FILL;
            end
          end
        end
        FILL: begin
          hold_c = 1'b1;
          if (bus.mem_ack) begin
            fill_wr = 1'b1;
            if (word_cnt == 2'd3) begin
              fill_done  = 1'b1;
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // A flush that lands mid-fill must still keep the finishing line invalid,
  // so it is remembered in pending; the flush itself clears valid last so it
  // always wins over a same-cycle fill completion.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid      <= '0;
      word_cnt   <= '0;
      pending    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      mem_addr_q <= START_ADDRESS;
      line_base  <= '0;
    end else begin
      if (do_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (do_miss) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
        line_base  <= bus.cpu_addr[31:4];
        word_cnt   <= '0;
        pending    <= 1'b0;
        mem_addr_q <= {bus.cpu_addr[31:4], 4'b0000};
      end
      if (fill_wr) begin
        word_cnt <= word_cnt + 2'd1;
        if (!fill_done) mem_addr_q <= {line_base, word_cnt + 2'd1, 2'b00};
      end
      if (fill_done) begin
        pending         <= 1'b0;
        valid[fill_idx] <= !pending;
      end
      if (bus.flush) begin
        valid <= '0;
        if ((state == FILL) && !fill_done) pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr)   data_mem[{fill_idx, word_cnt}] <= bus.mem_data;
    if (fill_done) tag_mem[fill_idx]              <= fill_tag;
  end

  always_comb begin
    bus.hold     = hold_c;
    bus.cpu_data = cpu_data_c;
    bus.mem_ce_n = !(reset_n && (state == FILL));
    bus.mem_addr = mem_addr_q;
    bus.hit_cnt  = hit_cnt_q;
    bus.miss_cnt = miss_cnt_q;
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: memory model returns addr ^ 0xA5A5A5A5 with a
// programmable number of wait cycles per word.
module tb_icache_dm;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   ack_period = 1;
  int   wait_cnt = 0;
  logic [31:0] ack_log [16];

  icache_dm_if bus ();

  icache_dm #(.LINES(16), .START_ADDRESS(32'h00400000)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_data = bus.mem_addr ^ 32'hA5A5A5A5;
  assign bus.mem_ack  = !bus.mem_ce_n && (wait_cnt == ack_period - 1);

  always @(posedge clk) begin
    if (bus.mem_ce_n || bus.mem_ack) wait_cnt <= 0;
    else                             wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that
  // consumed the hit cycle.
  task automatic fetch(input logic [31:0] addr, input logic flush_req, input int flush_word,
                       output int hcyc, output int acks, output int ce_cyc,
                       output logic [31:0] data);
    logic done;
    logic flush_done;
    hcyc = 0; acks = 0; ce_cyc = 0; data = '0; done = 1'b0; flush_done = 1'b0;
    bus.cpu_addr = addr;
    bus.cpu_rd   = 1'b1;
    bus.flush    = flush_req;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (!bus.mem_ce_n) ce_cyc++;
      if (!bus.mem_ce_n && bus.mem_ack) begin
        if (acks < 16) ack_log[acks] = bus.mem_addr;
        acks++;
      end
      if (!bus.hold) begin
        data = bus.cpu_data;
        done = 1'b1;
      end else begin
        hcyc++;
      end
      if (flush_word >= 0 && !flush_done && !bus.mem_ce_n &&
          bus.mem_addr[3:2] == flush_word[1:0]) begin
        bus.flush  = 1'b1;
        flush_done = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
    end
    bus.cpu_rd = 1'b0;
  endtask

  initial begin
    int h, a, c;
    logic [31:0] d;
    bus.cpu_rd   = 1'b1;
    bus.cpu_addr = 32'h00400004;
    bus.flush    = 1'b0;

    // reset with a request pending: outputs forced quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", {31'd0, bus.hold}, 32'd0);
    chk("rst_cpu_data", bus.cpu_data, 32'd0);
    @(posedge clk); #1;
    reset_n    = 1'b1;
    bus.cpu_rd = 1'b0;
    @(negedge clk);
    chk("rst_ce_n", {31'd0, bus.mem_ce_n}, 32'd1);
    chk("rst_mem_addr", bus.mem_addr, 32'h00400000);
    chk("rst_hit_cnt", bus.hit_cnt, 32'd0);
    chk("rst_miss_cnt", bus.miss_cnt, 32'd0);
    chk("idle_cpu_data", bus.cpu_data, 32'd0);
    chk("idle_hold", {31'd0, bus.hold}, 32'd0);
    @(posedge clk); #1;

    // cold fetch
    fetch(32'h00400004, 1'b0, -1, h, a, c, d);
    chk("cold_hold_cycles", h, 32'd5);
    chk("cold_acks", a, 32'd4);
    chk("cold_addr0", ack_log[0], 32'h00400000);
    chk("cold_addr1", ack_log[1], 32'h00400004);
    chk("cold_addr2", ack_log[2], 32'h00400008);
    chk("cold_addr3", ack_log[3], 32'h0040000C);
    chk("cold_data", d, 32'hA5E5A5A1);
    chk("cold_miss_cnt", bus.miss_cnt, 32'd1);
    chk("cold_hit_cnt", bus.hit_cnt, 32'd1);
    chk("cold_ce_n_after", {31'd0, bus.mem_ce_n}, 32'd1);
    chk("cold_mem_addr_hold", bus.mem_addr, 32'h0040000C);

    // hits on the same line
    fetch(32'h00400008, 1'b0, -1, h, a, c, d);
    chk("hit8_hold", h, 32'd0);
    chk("hit8_ce", c, 32'd0);
    chk("hit8_data", d, 32'hA5E5A5AD);
    fetch(32'h0040000C, 1'b0, -1, h, a, c, d);
    chk("hitC_hold", h, 32'd0);
    chk("hitC_ce", c, 32'd0);
    chk("hitC_data", d, 32'hA5E5A5A9);
    chk("hits_hit_cnt", bus.hit_cnt, 32'd3);
    chk("hits_miss_cnt", bus.miss_cnt, 32'd1);

    // flush while idle, then index-0 conflicts
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    fetch(32'h00400000, 1'b0, -1, h, a, c, d);
    chk("conf1_hold", h, 32'd5);
    chk("conf1_data", d, 32'hA5E5A5A5);
    fetch(32'h00400100, 1'b0, -1, h, a, c, d);
    chk("conf2_hold", h, 32'd5);
    chk("conf2_data", d, 32'hA5E5A4A5);
    fetch(32'h00400000, 1'b0, -1, h, a, c, d);
    chk("conf3_hold", h, 32'd5);
    chk("conf_miss_cnt", bus.miss_cnt, 32'd4);
    chk("conf_hit_cnt", bus.hit_cnt, 32'd6);

    // flush together with a hit: served now, line gone afterwards
    fetch(32'h00400004, 1'b1, -1, h, a, c, d);
    chk("flushhit_hold", h, 32'd0);
    chk("flushhit_data", d, 32'hA5E5A5A1);
    chk("flushhit_hit_cnt", bus.hit_cnt, 32'd7);
    fetch(32'h00400004, 1'b0, -1, h, a, c, d);
    chk("postflush_hold", h, 32'd5);
    chk("postflush_miss_cnt", bus.miss_cnt, 32'd5);

    // wait-state memory
    ack_period = 16;
    fetch(32'h00400200, 1'b0, -1, h, a, c, d);
    chk("slow_hold", h, 32'd65);
    chk("slow_acks", a, 32'd4);
    chk("slow_data", d, 32'hA5E5A7A5);
    chk("slow_miss_cnt", bus.miss_cnt, 32'd6);
    chk("slow_hit_cnt", bus.hit_cnt, 32'd9);
    ack_period = 1;

    // flush during the second word of a fill
    fetch(32'h00400300, 1'b0, 1, h, a, c, d);
    chk("midflush_hold", h, 32'd10);
    chk("midflush_acks", a, 32'd8);
    chk("midflush_data", d, 32'hA5E5A6A5);
    chk("midflush_miss_cnt", bus.miss_cnt, 32'd8);
    chk("midflush_hit_cnt", bus.hit_cnt, 32'd10);

    // reset in the middle of a fill
    bus.cpu_addr = 32'h00400400;
    bus.cpu_rd   = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_hold", {31'd0, bus.hold}, 32'd0);
    chk("midrst_cpu_data", bus.cpu_data, 32'd0);
    @(posedge clk); #1;
    reset_n    = 1'b1;
    bus.cpu_rd = 1'b0;
    @(negedge clk);
    chk("midrst_ce_n", {31'd0, bus.mem_ce_n}, 32'd1);
    chk("midrst_mem_addr", bus.mem_addr, 32'h00400000);
    chk("midrst_hit_cnt", bus.hit_cnt, 32'd0);
    chk("midrst_miss_cnt", bus.miss_cnt, 32'd0);
    @(posedge clk); #1;
    fetch(32'h00400400, 1'b0, -1, h, a, c, d);
    chk("afterrst_hold", h, 32'd5);
    chk("afterrst_data", d, 32'hA5E5A1A5);
    chk("afterrst_miss_cnt", bus.miss_cnt, 32'd1);
    chk("afterrst_hit_cnt", bus.hit_cnt, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
